// File: rtl/ahb_master_arbiter.sv
// ahb_master_arbiter: shares one AHB master port among NUM_M requesters,
// one single NONSEQ transfer per grant (address phase then data phase).
// Build option ARB_FIXED_PRIO_EN: fixed priority, lowest index wins.
// Without it (default) arbitration is round robin from rr_ptr.
module ahb_master_arbiter #(
    parameter int NUM_M  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      Hclk,
    input  logic                      Hreset,
    input  logic [NUM_M-1:0]          req,
    input  logic [NUM_M-1:0]          req_write,
    input  logic [NUM_M*ADDR_W-1:0]   req_addr,
    input  logic [NUM_M*DATA_W-1:0]   req_wdata,
    output logic [NUM_M-1:0]          gnt,
    output logic [NUM_M-1:0]          done,
    output logic [NUM_M-1:0]          err,
    output logic [DATA_W-1:0]         rdata,
    input  logic                      Hreadyout,
    input  logic [1:0]                Hresp,
    input  logic [DATA_W-1:0]         Hrdata,
    output logic                      Hwrite,
    output logic                      Hreadyin,
    output logic [1:0]                Htrans,
    output logic [ADDR_W-1:0]         Haddr,
    output logic [DATA_W-1:0]         Hwdata
);

    localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] addr_a  [NUM_M];
    logic [DATA_W-1:0] wdata_a [NUM_M];
    logic              found;
    logic [IDX_W-1:0]  win;
    logic              grant;
    logic [NUM_M-1:0]  gnt_d;
    logic [NUM_M-1:0]  done_d;
    logic [NUM_M-1:0]  err_d;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] hwdata_d;
    logic [DATA_W-1:0] wbuf;
    logic [DATA_W-1:0] wbuf_d;
    logic              hwrite_d;
    logic [1:0]        htrans_d;
    logic [ADDR_W-1:0] haddr_d;

    for (genvar g = 0; g < NUM_M; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   rr_sum;

    // Round robin: first requester at or after rr_ptr, wrapping to 0.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        rr_sum = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(NUM_M)) begin
                rr_sum = rr_sum - (IDX_W+1)'(NUM_M);
            end
            if (req[rr_sum[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = rr_sum[IDX_W-1:0];
            end
        end
    end

    // Pointer moves just past each new winner.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win == IDX_W'(NUM_M - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    // Next state and next registered outputs; completion may chain into a new grant.
    always_comb begin
        state_d  = state;
        gnt_d    = gnt;
        done_d   = '0;
        err_d    = '0;
        rdata_d  = rdata;
        hwdata_d = Hwdata;
        wbuf_d   = wbuf;
        hwrite_d = Hwrite;
        htrans_d = Htrans;
        haddr_d  = Haddr;
        grant    = 1'b0;
        unique case (state)
            S_IDLE: begin
                grant = found;
            end
            S_ADDR: begin
                if (Hreadyout) begin
                    state_d  = S_DATA;
                    htrans_d = 2'b00;
                    hwdata_d = wbuf;
                end
            end
            S_DATA: begin
                if (Hreadyout) begin
                    done_d   = gnt;
                    if (Hresp == 2'b01) begin
                        err_d = gnt;
                    end
                    if (!Hwrite) begin
                        rdata_d = Hrdata;
                    end
                    state_d  = S_IDLE;
                    gnt_d    = '0;
                    htrans_d = 2'b00;
                    grant    = found;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (grant) begin
            state_d  = S_ADDR;
            gnt_d    = NUM_M'(1) << win;
            htrans_d = 2'b10;
            haddr_d  = addr_a[win];
            hwrite_d = req_write[win];
            wbuf_d   = wdata_a[win];
        end
    end

    // State and output registers; reset aborts any transfer silently.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state    <= S_IDLE;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            rdata    <= '0;
            Hwdata   <= '0;
            wbuf     <= '0;
            Hwrite   <= 1'b0;
            Htrans   <= 2'b00;
            Haddr    <= '0;
            Hreadyin <= 1'b0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            done     <= done_d;
            err      <= err_d;
            rdata    <= rdata_d;
            Hwdata   <= hwdata_d;
            wbuf     <= wbuf_d;
            Hwrite   <= hwrite_d;
            Htrans   <= htrans_d;
            Haddr    <= haddr_d;
            Hreadyin <= 1'b1;
        end
    end

endmodule
